stack_ctrl: RTL and testbench
=============================

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL provide parameter DW, default 16, data width.
REQ-002 SHALL provide parameter AW, default 8, memory address width.
REQ-003 SHALL have ports: clk input 1 system clock; rst input 1 synchronous active-high reset.
REQ-004 SHALL have ports: push input 1, pop input 1, memread input 1, memwrt input 1 (all from the control decoder).
REQ-005 SHALL have ports: lsaddr input AW load/store address; lsdata input DW store data; pushdata input DW register value to push.
REQ-006 SHALL have ports: mem_rdata input DW synchronous data-memory read data, valid one cycle after mem_re.
REQ-007 SHALL have ports: mem_addr output AW; mem_wdata output DW; mem_we output 1; mem_re output 1.
REQ-008 SHALL have ports: stall output 1 PC/pipeline hold; popdata output DW; popvalid output 1; sp output AW stack pointer; overflow output 1; underflow output 1.

Function
REQ-009 SHALL implement FSM states IDLE, PUSH_WR, POP_RD, POP_WB.
REQ-010 Stack SHALL grow downward; sp points at the next free slot; empty = all-ones (0xFF), full = 0x00.
REQ-011 In IDLE with push=pop=0, memory port SHALL pass through combinationally: mem_addr=lsaddr, mem_wdata=lsdata, mem_we=memwrt, mem_re=memread; stall=0.
REQ-012 IDLE, push=1, pop=0: SHALL latch pushdata, assert stall this cycle, and go to PUSH_WR; mem_we=0 this cycle.
REQ-013 PUSH_WR: SHALL drive mem_we=1, mem_addr=sp, mem_wdata=latched data, stall=0; SHALL update sp<=sp-1; next state IDLE (push is 2 cycles).
REQ-014 IDLE, pop=1, push=0: SHALL assert stall and go to POP_RD.
REQ-015 POP_RD: SHALL drive mem_re=1, mem_addr=sp+1 (mod 2^AW), stall=1; SHALL update sp<=sp+1; next state POP_WB.
REQ-016 POP_WB: SHALL register popdata<=mem_rdata, assert popvalid for exactly this cycle, stall=0; next state IDLE (pop is 3 cycles).
REQ-017 popdata SHALL hold its last value until the next completed pop.
REQ-018 push=pop=1 in IDLE: SHALL be a no-op: no memory access, sp unchanged, stall=0.
REQ-019 push/pop SHALL take priority over memread/memwrt in the same cycle; load/store is dropped.
REQ-020 In non-IDLE states, push/pop/memread/memwrt inputs SHALL be ignored and the memory port SHALL be owned by the FSM.
REQ-021 mem_we and mem_re SHALL never both be 1 in the same cycle.

Reset
REQ-022 On rst=1 at a clk edge: state<=IDLE, sp<=all-ones, popdata<=0, popvalid<=0, overflow<=0, underflow<=0, latched data<=0.
REQ-023 Reset mid-operation SHALL abort: no mem_we or popvalid in the cycle after reset; sp SHALL NOT be decremented/incremented.

Configuration
REQ-024 Macro STACK_GUARD_EN, when defined: push in IDLE with sp==0 SHALL NOT transition or write; SHALL set overflow (sticky until reset); stall=0.
REQ-025 With STACK_GUARD_EN: pop in IDLE with sp==all-ones SHALL NOT transition; SHALL set underflow (sticky); popvalid stays 0.
REQ-026 Without STACK_GUARD_EN: overflow and underflow SHALL be tied 0. Push at sp==0 SHALL write address 0 and wrap sp to all-ones. Pop at all-ones SHALL read address 0 and wrap sp to 0.

Verification
REQ-027 Reset, push=1 with pushdata=0xBEEF for 1 cycle -> next cycle mem_we=1, mem_addr=0xFF, mem_wdata=0xBEEF; then sp=0xFE; stall high 1 cycle only.
REQ-028 After REQ-027, pop=1 -> POP_RD: mem_re=1, mem_addr=0xFF; POP_WB: popdata=0xBEEF, popvalid=1; sp=0xFF; stall high 2 cycles.
REQ-029 IDLE, memwrt=1, lsaddr=0x10, lsdata=0x1234 -> same cycle mem_we=1, mem_addr=0x10, mem_wdata=0x1234, stall=0; push=pop=1 -> no memory access, sp unchanged.
REQ-030 255 pushes, then a 256th push -> guard on: overflow=1, no mem_we, sp=0x00; guard off: write at 0x00, sp=0xFF.
REQ-031 Pop on empty stack -> guard on: underflow=1, popvalid never asserted, sp=0xFF; guard off: read at 0x00, sp=0x00.
REQ-032 rst asserted during POP_RD -> next cycle state IDLE, popvalid=0, sp=0xFF, stall=0.

Source files
------------

// File: rtl/stack_ctrl.sv
// Hardware stack controller sharing the data-memory port with load/store traffic.
// Define STACK_GUARD_EN to block pushes on full / pops on empty and flag them sticky.
module stack_ctrl #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          memread,
    input  logic          memwrt,
    input  logic [AW-1:0] lsaddr,
    input  logic [DW-1:0] lsdata,
    input  logic [DW-1:0] pushdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    output logic          stall,
    output logic [DW-1:0] popdata,
    output logic          popvalid,
    output logic [AW-1:0] sp,
    output logic          overflow,
    output logic          underflow
);

    typedef enum logic [1:0] {IDLE, PUSH_WR, POP_RD, POP_WB} state_t;

    localparam logic [AW-1:0] SP_EMPTY = '1;
    localparam logic [AW-1:0] SP_FULL  = '0;

    state_t        state, state_nxt;
    logic [AW-1:0] sp_nxt;
    logic [DW-1:0] pushreg;
    logic          latch_en;
    logic          guard_full;
    logic          guard_empty;

    // Guard conditions and sticky error flags
`ifdef STACK_GUARD_EN
    assign guard_full  = (sp == SP_FULL);
    assign guard_empty = (sp == SP_EMPTY);

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (state == IDLE) begin
            if (push && !pop && guard_full)
                overflow <= 1'b1;
            if (pop && !push && guard_empty)
                underflow <= 1'b1;
        end
    end
`else
    assign guard_full  = 1'b0;
    assign guard_empty = 1'b0;
    assign overflow    = 1'b0;
    assign underflow   = 1'b0;
`endif

    // State, stack pointer and pop result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sp       <= SP_EMPTY;
            popdata  <= '0;
            popvalid <= 1'b0;
            pushreg  <= '0;
        end else begin
            state    <= state_nxt;
            sp       <= sp_nxt;
            popvalid <= (state == POP_WB);
            if (state == POP_WB)
                popdata <= mem_rdata;
            if (latch_en)
                pushreg <= pushdata;
        end
    end

    // Next state and memory-port ownership
    always_comb begin
        state_nxt = state;
        sp_nxt    = sp;
        latch_en  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (push && !pop) begin
                    if (!guard_full) begin
                        latch_en  = 1'b1;
                        stall     = 1'b1;
                        state_nxt = PUSH_WR;
                    end
                end else if (pop && !push) begin
                    if (!guard_empty) begin
                        stall     = 1'b1;
                        state_nxt = POP_RD;
                    end
                end else if (!push && !pop) begin
                    mem_addr  = lsaddr;
                    mem_wdata = lsdata;
                    mem_we    = memwrt;
                    // a write wins so the port never sees read and write together
                    mem_re    = memread && !memwrt;
                end
            end
            PUSH_WR: begin
                mem_we    = 1'b1;
                mem_addr  = sp;
                mem_wdata = pushreg;
                sp_nxt    = sp - AW'(1);
                state_nxt = IDLE;
            end
            POP_RD: begin
                mem_re    = 1'b1;
                mem_addr  = sp + AW'(1);
                stall     = 1'b1;
                sp_nxt    = sp + AW'(1);
                state_nxt = POP_WB;
            end
            POP_WB: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a synchronous memory and a popdata scoreboard.
module tb_stack_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        push, pop, memread, memwrt;
    logic [7:0]  lsaddr;
    logic [15:0] lsdata, pushdata, mem_rdata;
    logic [7:0]  mem_addr, sp;
    logic [15:0] mem_wdata, popdata;
    logic        mem_we, mem_re, stall, popvalid, overflow, underflow;

    int checks = 0;
    int errors = 0;
    logic [15:0] model_stk[$];
    logic [15:0] exp_q[$];
    logic [15:0] tmem [256];

    always #5 clk = ~clk;

    stack_ctrl #(.DW(16), .AW(8)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .memread(memread), .memwrt(memwrt),
        .lsaddr(lsaddr), .lsdata(lsdata), .pushdata(pushdata), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .stall(stall), .popdata(popdata), .popvalid(popvalid), .sp(sp),
        .overflow(overflow), .underflow(underflow)
    );

    // Synchronous data memory, read data valid one cycle after mem_re
    always @(posedge clk) begin
        if (mem_we) tmem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= tmem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("we_re_exclusive", 32'(mem_we && mem_re), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_stk.delete();
        exp_q.delete();
    endtask

    task automatic do_push(input logic [15:0] d);
        push = 1'b1;
        pushdata = d;
        model_stk.push_back(d);
        step();
        push = 1'b0;
        pushdata = ~d;
        #1;
        chk("push_wdata", mem_wdata, d);
        step();
    endtask

    task automatic wait_popvalid();
        int n = 0;
        while (!popvalid && n < 6) begin
            step();
            n++;
        end
        chk("popvalid_seen", popvalid, 1);
        chk("popdata", popdata, exp_q.pop_front());
    endtask

    task automatic do_pop();
        pop = 1'b1;
        exp_q.push_back(model_stk.pop_back());
        step();
        pop = 1'b0;
        wait_popvalid();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tmem[i] = '0;
        rst = 1'b1; push = 0; pop = 0; memread = 0; memwrt = 0;
        lsaddr = '0; lsdata = '0; pushdata = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_sp", sp, 8'hFF);
        chk("rst_popvalid", popvalid, 0);
        chk("rst_popdata", popdata, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_stall", stall, 0);

        // Single push of 0xBEEF
        push = 1'b1; pushdata = 16'hBEEF; model_stk.push_back(16'hBEEF);
        #1;
        chk("push_stall", stall, 1);
        chk("push_idle_we", mem_we, 0);
        step();
        push = 1'b0; pushdata = 16'h0000;
        #1;
        chk("pushwr_we", mem_we, 1);
        chk("pushwr_addr", mem_addr, 8'hFF);
        chk("pushwr_wdata", mem_wdata, 16'hBEEF);
        chk("pushwr_stall", stall, 0);
        step();
        chk("push_sp", sp, 8'hFE);
        chk("push_stall_after", stall, 0);

        // Single pop, with a stray store ignored while the FSM owns the port
        pop = 1'b1; exp_q.push_back(model_stk.pop_back());
        #1;
        chk("pop_stall_idle", stall, 1);
        step();
        pop = 1'b0; memwrt = 1'b1; lsaddr = 8'h33;
        #1;
        chk("poprd_re", mem_re, 1);
        chk("poprd_we", mem_we, 0);
        chk("poprd_addr", mem_addr, 8'hFF);
        chk("poprd_stall", stall, 1);
        step();
        memwrt = 1'b0;
        chk("popwb_stall", stall, 0);
        chk("popwb_sp", sp, 8'hFF);
        chk("popwb_we", mem_we, 0);
        wait_popvalid();
        step();
        chk("popvalid_one_cycle", popvalid, 0);
        chk("popdata_hold", popdata, 16'hBEEF);

        // Load/store pass-through and push+pop no-op
        memwrt = 1'b1; lsaddr = 8'h10; lsdata = 16'h1234;
        #1;
        chk("ls_we", mem_we, 1);
        chk("ls_addr", mem_addr, 8'h10);
        chk("ls_wdata", mem_wdata, 16'h1234);
        chk("ls_stall", stall, 0);
        step();
        memwrt = 1'b0; memread = 1'b1;
        #1;
        chk("ld_re", mem_re, 1);
        chk("ld_we", mem_we, 0);
        step();
        memread = 1'b0;
        chk("ld_rdata", mem_rdata, 16'h1234);
        push = 1'b1; pop = 1'b1; memwrt = 1'b1;
        #1;
        chk("both_we", mem_we, 0);
        chk("both_re", mem_re, 0);
        chk("both_stall", stall, 0);
        step();
        push = 1'b0; pop = 1'b0; memwrt = 1'b0;
        chk("both_sp", sp, 8'hFF);

        // LIFO ordering with the pushed value changed during PUSH_WR
        do_push(16'hA001); do_push(16'hA002); do_push(16'hA003);
        chk("lifo_sp", sp, 8'hFC);
        push = 1'b1; memwrt = 1'b1;
        #1;
        chk("push_drops_store", mem_we, 0);
        push = 1'b0; memwrt = 1'b0;
        do_pop(); do_pop(); do_pop();
        chk("lifo_sp_end", sp, 8'hFF);

        // Fill to sp == 0 then push once more
        do_reset();
        for (int i = 0; i < 255; i++) do_push(16'(16'h0100 + i));
        chk("fill_sp", sp, 8'h00);
        push = 1'b1; pushdata = 16'hF00D;
`ifdef STACK_GUARD_EN
        #1;
        chk("ovf_stall", stall, 0);
        step();
        push = 1'b0;
        chk("ovf_we", mem_we, 0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_sp", sp, 8'h00);
        step();
        chk("ovf_sticky", overflow, 1);
`else
        model_stk.push_back(16'hF00D);
        step();
        push = 1'b0;
        chk("wrap_we", mem_we, 1);
        chk("wrap_addr", mem_addr, 8'h00);
        step();
        chk("wrap_sp", sp, 8'hFF);
        chk("wrap_overflow", overflow, 0);
`endif
        do_pop(); do_pop();

        // Pop on an empty stack
        do_reset();
`ifdef STACK_GUARD_EN
        pop = 1'b1;
        #1;
        chk("unf_stall", stall, 0);
        step();
        pop = 1'b0;
        chk("unf_flag", underflow, 1);
        chk("unf_sp", sp, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("unf_popvalid", popvalid, 0);
        end
`else
        pop = 1'b1; exp_q.push_back(16'hF00D);
        step();
        pop = 1'b0;
        chk("empty_re", mem_re, 1);
        chk("empty_addr", mem_addr, 8'h00);
        step();
        chk("empty_sp", sp, 8'h00);
        chk("empty_underflow", underflow, 0);
        wait_popvalid();
`endif

        // Reset during POP_RD aborts the pop
        do_reset();
        do_push(16'h5A5A);
        pop = 1'b1;
        step();
        pop = 1'b0; rst = 1'b1;
        #1;
        chk("abort_poprd_re", mem_re, 1);
        step();
        rst = 1'b0;
        chk("abort_pop_stall", stall, 0);
        chk("abort_pop_popvalid", popvalid, 0);
        chk("abort_pop_sp", sp, 8'hFF);
        chk("abort_pop_re", mem_re, 0);
        step();
        chk("abort_pop_popvalid2", popvalid, 0);

        // Reset during PUSH_WR aborts the push
        push = 1'b1; pushdata = 16'h7777;
        step();
        push = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_push_we", mem_we, 0);
        chk("abort_push_sp", sp, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
